// File: rtl/soc_system_nios_cpu_pio_out.sv
// rtl/soc_system_nios_cpu_pio_out.sv - Avalon-MM output PIO with set/clear and optional pulse register
// Optional self-clearing pulse register at address 6 is built when SOC_PIO_OUT_PULSE_EN is defined.
module soc_system_nios_cpu_pio_out #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESET_VALUE  = 0,
    parameter int PULSE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);
    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_DIR   = 3'd1;
    localparam logic [2:0] ADDR_SET   = 3'd4;
    localparam logic [2:0] ADDR_CLR   = 3'd5;
    localparam logic [2:0] ADDR_PULSE = 3'd6;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [31:0]           rd_d;
    logic                  unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd               = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign out_port         = data_q;

`ifdef SOC_PIO_OUT_PULSE_EN
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} pulse_state_t;

    pulse_state_t          state_q;
    pulse_state_t          state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] pmask_q;
    logic [DATA_WIDTH-1:0] pmask_d;
    logic                  pulse_wr;
    logic                  expire;
    logic                  busy;

    assign pulse_wr = wr && (address == ADDR_PULSE) && (wd != '0);
    assign busy     = (state_q == ST_ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pmask_q <= pmask_d;
        end
    end

    // A nonzero PULSE write always wins over expiry: reload and merge masks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pmask_d = pmask_q;
        expire  = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    expire  = 1'b1;
                    pmask_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pulse_wr) begin
            expire  = 1'b0;
            pmask_d = pmask_q | wd;
            cnt_d   = CW'(PULSE_CYCLES - 1);
            state_d = ST_ACTIVE;
        end
    end
`endif

    // Register writes land first; the pulse engine then sets or clears on top.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA: data_d = wd;
                ADDR_SET:  data_d = data_q | wd;
                ADDR_CLR:  data_d = data_q & ~wd;
                default:   ;
            endcase
        end
`ifdef SOC_PIO_OUT_PULSE_EN
        if (pulse_wr) begin
            data_d = data_d | wd;
        end else if (expire) begin
            data_d = data_d & ~pmask_q;
        end
`endif
    end

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d[DATA_WIDTH-1:0] = data_q;
            ADDR_DIR:  rd_d[DATA_WIDTH-1:0] = '1;
`ifdef SOC_PIO_OUT_PULSE_EN
            ADDR_PULSE: begin
                rd_d[DATA_WIDTH-1:0] = pmask_q;
                rd_d[31]             = busy;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= DATA_WIDTH'(RESET_VALUE);
            readdata <= '0;
        end else begin
            data_q   <= data_d;
            readdata <= rd_d;
        end
    end
endmodule

// File: tb/tb_soc_system_nios_cpu_pio_out.sv
// tb/tb_soc_system_nios_cpu_pio_out.sv - directed and randomized bench for the output PIO
module tb_soc_system_nios_cpu_pio_out;
    localparam int DW = 8;
    localparam int PC = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int tests = 0;
    int fails = 0;

    // Reference model: data register plus a pulse deadline expressed in edge numbers.
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_pmask;
    bit            m_active;
    int            m_deadline;
    int            edge_n;
    bit            pulse_en;

    soc_system_nios_cpu_pio_out #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (0),
        .PULSE_CYCLES(PC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[DW-1:0] = m_data;
            3'd1: r[DW-1:0] = '1;
            3'd6: if (pulse_en) begin
                r[DW-1:0] = m_pmask;
                r[31]     = m_active;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data   = '0;
        m_pmask  = '0;
        m_active = 1'b0;
    endtask

    task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] wdat);
        logic [31:0]   exp_rd;
        logic [DW-1:0] w;
        address   = a;
        writedata = wdat;
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
        end
        exp_rd = model_read(a);
        edge_n++;
        w = wdat[DW-1:0];
        if (wr) begin
            case (a)
                3'd0: m_data = w;
                3'd4: m_data = m_data | w;
                3'd5: m_data = m_data & ~w;
                default: ;
            endcase
        end
        if (pulse_en && wr && a == 3'd6 && w != '0) begin
            m_data     = m_data | w;
            m_pmask    = m_pmask | w;
            m_active   = 1'b1;
            m_deadline = edge_n + PC;
        end else if (m_active && edge_n == m_deadline) begin
            m_data   = m_data & ~m_pmask;
            m_pmask  = '0;
            m_active = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_port_model", 32'(out_port), 32'(m_data));
        check("readdata_model", readdata, exp_rd);
    endtask

    task automatic idle();
        step(1'b0, 3'($urandom_range(0, 7)), $urandom);
    endtask

    initial begin
`ifdef SOC_PIO_OUT_PULSE_EN
        pulse_en = 1'b1;
`else
        pulse_en = 1'b0;
`endif
        edge_n     = 0;
        m_deadline = 0;
        model_reset();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_port", 32'(out_port), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            step(1'b0, 3'(a), 32'h0);
            check("reset_map_read", readdata, (a == 1) ? 32'h0000_00FF : 32'h0);
        end

        step(1'b1, 3'd0, 32'h0000_00A5);
        check("data_write", 32'(out_port), 32'hA5);
        step(1'b1, 3'd4, 32'h0000_000A);
        check("outset_write", 32'(out_port), 32'hAF);
        step(1'b1, 3'd5, 32'h0000_0081);
        check("outclear_write", 32'(out_port), 32'h2E);
        step(1'b0, 3'd0, 32'h0);
        check("data_readback", readdata, 32'h0000_002E);

        if (pulse_en) begin
            step(1'b1, 3'd0, 32'h0);
            step(1'b1, 3'd6, 32'h03);
            check("pulse_high_0", 32'(out_port), 32'h03);
            step(1'b0, 3'd6, 32'h0);
            check("pulse_high_1", 32'(out_port), 32'h03);
            check("pulse_busy_read", readdata, 32'h8000_0003);
            idle();
            check("pulse_high_2", 32'(out_port), 32'h03);
            idle();
            check("pulse_high_3", 32'(out_port), 32'h03);
            idle();
            check("pulse_fall", 32'(out_port), 32'h00);
            step(1'b0, 3'd6, 32'h0);
            check("pulse_idle_read", readdata, 32'h0);

            step(1'b1, 3'd6, 32'h01);
            idle();
            idle();
            step(1'b1, 3'd6, 32'h10);
            check("retrig_0", 32'(out_port), 32'h11);
            for (int i = 1; i < PC; i++) begin
                idle();
                check("retrig_held", 32'(out_port), 32'h11);
            end
            idle();
            check("retrig_fall", 32'(out_port), 32'h00);

            step(1'b1, 3'd6, 32'h01);
            for (int i = 1; i < PC; i++) idle();
            step(1'b1, 3'd4, 32'h40);
            check("outset_at_expiry", 32'(out_port), 32'h40);

            step(1'b1, 3'd0, 32'hFF);
            step(1'b1, 3'd6, 32'h0F);
            idle();
            reset_n = 1'b0;
            #1;
            check("async_reset_out", 32'(out_port), 32'h00);
            model_reset();
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            step(1'b1, 3'd0, 32'h01);
            for (int i = 0; i < 3 * PC; i++) begin
                idle();
                check("post_reset_hold", 32'(out_port), 32'h01);
            end
        end else begin
            step(1'b1, 3'd0, 32'h5A);
            step(1'b1, 3'd6, 32'hFF);
            check("no_pulse_write", 32'(out_port), 32'h5A);
            step(1'b0, 3'd6, 32'h0);
            check("no_pulse_read", readdata, 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4) idle();
            else if (kind < 7) step(1'b1, 3'd6, (kind == 4) ? 32'h0 : $urandom);
            else step(1'b1, 3'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/soc_system_nios_cpu_pio_out.md
# soc_system_nios_cpu_pio_out

Avalon-MM slave output PIO that lets the Nios II CPU drive an 8-bit parallel output bus (LEDs, relay/lock strobes) from a memory-mapped data register. It is the write-direction counterpart of the system's input PIO and sits on the same CPU data master. Atomic set and clear registers allow single-bit updates without read-modify-write. An optional self-clearing pulse register produces timed strobes.

## Interface
- DATA_WIDTH, 8, width of `out_port` and of the data register (1..32)
- RESET_VALUE, 0, value of the data register and `out_port` after reset
- PULSE_CYCLES, 50000, pulse length in `clk` cycles (≥1); the counter is `$clog2(PULSE_CYCLES+1)` bits wide

- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  word address of register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by `chipselect`
- writedata  input  32  write data; only bits [DATA_WIDTH-1:0] are used
- readdata  output  32  registered read data; unused upper bits are 0
- out_port  output  DATA_WIDTH  parallel output; driven directly from the data register

## Operation
- A write strobe (`wr`) occurs in any cycle where `chipselect` = 1 and `write_n` = 0. There are no wait states.
- Register map (word addresses):
  - 0 DATA: a write loads `writedata`; a read returns the data register.
  - 1 DIRECTION: a read returns all ones in [DATA_WIDTH-1:0]; writes are ignored.
  - 4 OUTSET: a write sets data bits where `writedata` = 1; a read returns 0.
  - 5 OUTCLEAR: a write clears data bits where `writedata` = 1; a read returns 0.
  - 6 PULSE: present only when the macro is defined (see Configuration).
  - 2, 3, 7: reserved; a read returns 0 and writes are ignored.
- `readdata` is registered every cycle from the `address` mux. It does not depend on `chipselect`.
- Pulse engine state:
  - State IDLE: busy = 0.
  - State ACTIVE: busy = 1; counter `cnt` and mask `pmask` are held.
- Pulse engine transitions:
  - A PULSE write with nonzero data:
    - data |= wd
    - pmask |= wd
    - cnt ← PULSE_CYCLES-1
    - → ACTIVE
    - This applies from either state, so a write during ACTIVE retriggers the pulse and merges the masks.
  - A PULSE write with zero data: no effect.
  - In ACTIVE with cnt ≠ 0: cnt decrements by 1.
  - In ACTIVE with cnt = 0 (expiry):
    - data &= ~pmask
    - pmask ← 0
    - → IDLE
- Simultaneous events:
  - PULSE write in the expiry cycle: the write wins. The counter reloads, the masks merge and no bits are cleared.
  - DATA, OUTSET or OUTCLEAR write in the expiry cycle: the write is applied first, then the expiry clear masks the result with ~pmask.
  - A DATA or OUTCLEAR write during ACTIVE does not cancel the pulse timer.
- Reset, asserted at any time including mid-pulse:
  - data = RESET_VALUE, `out_port` = RESET_VALUE
  - `readdata` = 0
  - pmask = 0, cnt = 0, state IDLE
  - The reset takes effect immediately and asynchronously.

## Timing
- A write at rising edge T is visible on `out_port` after edge T, which is 1 cycle of latency.
- Read: with `address` presented in cycle T, `readdata` is valid after edge T. This gives an Avalon read latency of 1.
- Pulse: after a PULSE write at edge T, the affected bits are high for exactly PULSE_CYCLES cycles and fall after edge T+PULSE_CYCLES.
- With PULSE_CYCLES = 1, the bits are high for exactly one cycle.
- The counter never wraps. It stops at 0 in IDLE.

## Configuration
- Macro `SOC_PIO_OUT_PULSE_EN`.
- Defined:
  - The PULSE register at address 6 is implemented.
  - A read returns {busy at bit 31, 0, pmask in [DATA_WIDTH-1:0]}.
- Undefined:
  - The counter, mask and state logic are absent.
  - Address 6 behaves as reserved: a read returns 0 and writes are ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then a read of addresses 0..7 → `out_port` = 0x00. Reads return 0 everywhere except address 1, which returns 0x000000FF.
- Write DATA = 0xA5, then OUTSET 0x0A, then OUTCLEAR 0x81 → `out_port` = 0xA5, 0xAF, 0x2E, each one cycle after its write. Reading DATA returns 0x0000002E.
- PULSE_CYCLES = 4 with the macro defined:
  - From DATA = 0x00, write PULSE 0x03 → `out_port` = 0x03 for exactly 4 cycles, then 0x00.
  - Reading PULSE mid-pulse returns 0x80000003; after expiry it returns 0x00000000.
- Retrigger and simultaneous events, PULSE_CYCLES = 4:
  - Write PULSE 0x01, then two cycles later PULSE 0x10 → bits 0x11 both fall 4 cycles after the second write.
  - An OUTSET 0x40 issued in the expiry cycle is followed by `out_port` = 0x40.
- Assert `reset_n` = 0 mid-pulse with DATA = 0xFF → `out_port` = 0x00 immediately. After release, no spurious clear occurs, and a DATA write of 0x01 is held indefinitely.
- Build without `SOC_PIO_OUT_PULSE_EN`, then write address 6 with 0xFF → `out_port` is unchanged and a read of address 6 returns 0.
